// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for the decode stage
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_op;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_illegal, out_pc
    );
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_illegal, out_pc
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I/M to ALU decode behind a two-entry skid buffer with registered in_ready
module decode_stage #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    decode_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                           OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_NOT = 4'b0101,
                           OP_DIV = 4'b0110, OP_MUL = 4'b0111, OP_SLL = 4'b1000,
                           OP_SRL = 4'b1001;
    typedef struct packed {
        logic [3:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
    state_t          r_state, w_state_nx;
    entry_t          r_h, r_s, w_dec;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_imm;
    logic            w_legal, w_use_imm;
    logic            w_accept, w_pop, w_load_h, w_load_s, w_h_from_s;
    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    assign w_opc = bus.in_instr[6:0];
    assign w_f3  = bus.in_instr[14:12];
    assign w_f7  = bus.in_instr[31:25];
    always_comb begin
        w_op      = OP_ADD;
        w_legal   = 1'b0;
        w_use_imm = 1'b0;
        w_imm     = '0;
        if (w_opc == 7'b0110011) begin
            w_legal = 1'b1;
            case ({w_f7, w_f3})
                10'b0000000_000: w_op = OP_ADD;
                10'b0000000_111: w_op = OP_AND;
                10'b0000000_110: w_op = OP_OR;
                10'b0000000_100: w_op = OP_XOR;
                10'b0000000_001: w_op = OP_SLL;
                10'b0000000_101: w_op = OP_SRL;
                10'b0100000_000: w_op = OP_SUB;
                10'b0000001_000: w_op = OP_MUL;
                10'b0000001_100: w_op = OP_DIV;
                default:         w_legal = 1'b0;
            endcase
        end else if (w_opc == 7'b0010011) begin
            w_legal   = 1'b1;
            w_use_imm = 1'b1;
            w_imm     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
            case (w_f3)
                3'b000:  w_op = OP_ADD;
                3'b111:  w_op = OP_AND;
                3'b110:  w_op = OP_OR;
                3'b100:  w_op = &bus.in_instr[31:20] ? OP_NOT : OP_XOR;
                3'b001, 3'b101: begin
                    w_op    = w_f3[2] ? OP_SRL : OP_SLL;
                    w_legal = (w_f7 == 7'b0);
                    w_imm   = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                end
                default: w_legal = 1'b0;
            endcase
        end
        if (!w_legal) begin
            w_op      = OP_ADD;
            w_use_imm = 1'b0;
            w_imm     = '0;
        end
    end
    assign w_dec = '{op: w_op, rs1: bus.in_instr[19:15], rs2: bus.in_instr[24:20],
                     rd: bus.in_instr[11:7], imm: w_imm, use_imm: w_use_imm,
                     illegal: !w_legal, pc: bus.in_pc};
    assign bus.in_ready  = (r_state != S_TWO) && !rst;
    assign bus.out_valid = (r_state != S_EMPTY);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;
    always_comb begin
        w_state_nx = r_state;
        w_load_h   = 1'b0;
        w_load_s   = 1'b0;
        w_h_from_s = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_load_h   = w_accept;
                w_state_nx = w_accept ? S_ONE : S_EMPTY;
            end
            S_ONE: begin
                w_load_h   = w_accept && w_pop;
                w_load_s   = w_accept && !w_pop;
                w_state_nx = (w_accept && !w_pop) ? S_TWO : (!w_accept && w_pop) ? S_EMPTY : S_ONE;
            end
            S_TWO: begin
                w_h_from_s = w_pop;
                w_state_nx = w_pop ? S_ONE : S_TWO;
            end
            default: w_state_nx = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nx = S_EMPTY;
            w_load_h   = 1'b0;
            w_load_s   = 1'b0;
            w_h_from_s = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_h     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_load_h) r_h <= w_dec;
            else if (w_h_from_s) r_h <= r_s;
            if (w_load_s) r_s <= w_dec;
        end
    end
    assign bus.out_op      = r_h.op;
    assign bus.out_rs1     = r_h.rs1;
    assign bus.out_rs2     = r_h.rs2;
    assign bus.out_rd      = r_h.rd;
    assign bus.out_imm     = r_h.imm;
    assign bus.out_use_imm = r_h.use_imm;
    assign bus.out_illegal = r_h.illegal;
    assign bus.out_pc      = r_h.pc;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a queue-based decode reference
module tb_decode_stage;
    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
        logic [31:0] pc;
    } dec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    dec_t q[$];
    dec_t shown = '0;
    decode_stage_if #(.XLEN(32)) bus ();
    decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
    always #5 clk = ~clk;
    function automatic dec_t ref_dec(logic [31:0] w, logic [31:0] pc);
        dec_t d;
        int op;
        bit ui;
        logic [31:0] imm;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        op = -1; ui = 0; imm = 0;
        if (opc == 7'h33 && f7 == 7'h00) begin
            if (f3 == 0) op = 0; else if (f3 == 7) op = 2; else if (f3 == 6) op = 3;
            else if (f3 == 4) op = 4; else if (f3 == 1) op = 8; else if (f3 == 5) op = 9;
        end else if (opc == 7'h33 && f7 == 7'h20) begin
            if (f3 == 0) op = 1;
        end else if (opc == 7'h33 && f7 == 7'h01) begin
            if (f3 == 0) op = 7; else if (f3 == 4) op = 6;
        end else if (opc == 7'h13) begin
            ui = 1;
            imm = {{20{w[31]}}, w[31:20]};
            if (f3 == 0) op = 0; else if (f3 == 7) op = 2; else if (f3 == 6) op = 3;
            else if (f3 == 4) op = (w[31:20] == 12'hFFF) ? 5 : 4;
            else if ((f3 == 1 || f3 == 5) && f7 == 0) begin
                op = (f3 == 1) ? 8 : 9;
                imm = {27'b0, w[24:20]};
            end
        end
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; d.pc = pc;
        d.illegal = (op < 0);
        d.op = (op < 0) ? 4'd0 : op[3:0];
        d.use_imm = (op < 0) ? 1'b0 : ui;
        d.imm = (op < 0) ? 32'd0 : imm;
        return d;
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic step();
        bit acc, pop;
        acc = bus.in_valid && !rst && (q.size() < 2);
        pop = (q.size() > 0) && bus.out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            shown = '0;
        end else if (flush) q.delete();
        else begin
            if (pop) q.delete(0);
            if (acc) q.push_back(ref_dec(bus.in_instr, bus.in_pc));
        end
        if (q.size() > 0) shown = q[0];
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && q.size() < 2));
        chk("op", 32'(bus.out_op), 32'(shown.op));
        chk("rs1", 32'(bus.out_rs1), 32'(shown.rs1));
        chk("rs2", 32'(bus.out_rs2), 32'(shown.rs2));
        chk("rd", 32'(bus.out_rd), 32'(shown.rd));
        chk("imm", bus.out_imm, shown.imm);
        chk("use_imm", 32'(bus.out_use_imm), 32'(shown.use_imm));
        chk("illegal", 32'(bus.out_illegal), 32'(shown.illegal));
        chk("pc", bus.out_pc, shown.pc);
    endtask
    task automatic offer(logic [31:0] w, logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_pc = pc;
        step();
    endtask
    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end else if (k < 8) begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 2) == 0) w[31:25] = 7'h00;
            if ($urandom_range(0, 3) == 0) w[31:20] = 12'hFFF;
        end
        return w;
    endfunction
    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b1;
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        offer(32'h002081B3, 32'h100);
        chk("add_op", 32'(bus.out_op), 32'd0);
        chk("add_rd", 32'(bus.out_rd), 32'd3);
        offer(32'h407302B3, 32'h104);
        chk("sub_op", 32'(bus.out_op), 32'd1);
        offer(32'h023140B3, 32'h108);
        chk("div_op", 32'(bus.out_op), 32'd6);
        offer(32'hFFB00093, 32'h10C);
        chk("addi_imm", bus.out_imm, 32'hFFFFFFFB);
        chk("addi_use_imm", 32'(bus.out_use_imm), 32'd1);
        offer(32'hFFF14093, 32'h110);
        chk("not_op", 32'(bus.out_op), 32'd5);
        offer(32'h403150B3, 32'h114);
        chk("sra_illegal", 32'(bus.out_illegal), 32'd1);
        chk("sra_rd", 32'(bus.out_rd), 32'd1);
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        offer(32'h00310233, 32'h200);
        offer(32'h0041F2B3, 32'h204);
        offer(32'h00526333, 32'h208);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_head_pc", bus.out_pc, 32'h200);
        step();
        bus.out_ready = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        bus.out_ready = 1'b0;
        offer(32'h00A00513, 32'h300);
        offer(32'h00B00593, 32'h304);
        flush = 1'b1;
        offer(32'h00C00613, 32'h308);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        step();
        offer(32'h00D00693, 32'h30C);
        flush = 1'b1;
        offer(32'h00E00713, 32'h310);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        step();
        offer(32'h00F00793, 32'h400);
        offer(32'h01000813, 32'h404);
        rst = 1'b1;
        step();
        chk("rst_full_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_full_pc", bus.out_pc, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_instr = rand_instr();
            bus.in_pc = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
